seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Multi-cycle signed 16x16 multiplier inside the datapath, implementing the MUL instruction extension.
- Takes SR1/SR2 register-file outputs and drives the bus through the GateMUL tristate/mux (the gate itself lives in the datapath).
- Handshakes with the control unit's ISDU FSM via MUL_EN (start/hold) and MUL_R (ready); the FSM waits in its MUL state until MUL_R.

Parameters:
WIDTH, 16, operand and result width in bits (counter width is clog2(WIDTH)+1).

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  asynchronous, active-low reset (0 = reset)
MUL_EN  input  1  start/hold request from control unit, level-sensitive
A  input  WIDTH  multiplicand (SR1), two's complement
B  input  WIDTH  multiplier (SR2), two's complement
Product  output  WIDTH  low WIDTH bits of signed A*B; drives GateMUL source
Overflow  output  1  1 if the full 2*WIDTH product does not fit in signed WIDTH
MUL_R  output  1  result ready

Behaviour:
- Reset=0, asynchronously: state=IDLE, Product=0, Overflow=0, MUL_R=0, count=0, internal regs=0. Deassertion of Reset takes effect at the next rising edge.
- States:
  - IDLE: MUL_R=0. On an edge with MUL_EN=1, capture |A| and |B| as unsigned magnitudes (|0x8000| = 0x8000). Capture result sign = A[MSB]^B[MSB]. Clear the 2*WIDTH accumulator, set count=0, go to CALC.
  - CALC: one shift-add iteration per edge: if multiplier LSB=1, acc += multiplicand << count; then shift multiplier right, count++.
    - On the edge where count reaches WIDTH-1→WIDTH (the WIDTH-th iteration), go to DONE.
    - On that same edge, load Product and Overflow from the sign-corrected next accumulator (two's-complement negate if sign=1, else pass through).
    - If MUL_EN=0 at any CALC edge: abort to IDLE. Product, Overflow and MUL_R are left unchanged (MUL_R=0).
  - DONE: MUL_R=1 (decoded from state, glitch-free, no combinational path from inputs). Stay while MUL_EN=1. On an edge with MUL_EN=0, go to IDLE.
- Handshake:
  - No restart while MUL_EN is held high after completion; the FSM must drop MUL_EN for at least one edge.
  - Product/Overflow hold their last result indefinitely until the next completed multiply.
- Latency: MUL_R rises exactly WIDTH rising edges after the edge that samples MUL_EN=1 in IDLE (16 for default). Throughput: one result per WIDTH+2 cycles minimum.
- A and B are sampled only at the start edge; changes during CALC have no effect.
- Arithmetic:
  - Full product is 2*WIDTH bits.
  - Overflow=1 iff bits [2*WIDTH-1:WIDTH-1] of the signed full product are not all equal.
  - A zero operand gives Product=0, Overflow=0, regardless of the other operand's sign (no negative zero issue: negate of 0 is 0).
- Reset asserted mid-CALC or in DONE: immediate return to the reset values above.

Decomposition:
- Shared package (datapath package): mul_state_t enum {IDLE, CALC, DONE} and the MUL_WIDTH constant = 16. Also the GateMUL bus-select encoding, if the bus mux uses an enum.
- Single module; no sub-module is natural. The magnitude/negate logic is two small functions in the package (abs_val, neg_val) reusable by the ALU.

Test Plan:
- Reset=0 mid-CALC of 3*5, then release → Product=0, MUL_R=0, state IDLE. A fresh MUL_EN restarts cleanly.
- A=3, B=5, MUL_EN held high → MUL_R=1 exactly 16 edges after the start edge; Product=0x000F, Overflow=0. MUL_R stays 1 until MUL_EN=0, then drops the next edge.
- A=0xFFF9 (-7), B=6 → Product=0xFFD6 (-42), Overflow=0. A=0, B=0x8000 → Product=0x0000, Overflow=0.
- A=0x7FFF, B=2 → Product=0xFFFE, Overflow=1. A=0x8000, B=0xFFFF → Product=0x8000, Overflow=1.
- Start 4*4 (result 0x0010), then start 9*9 and drop MUL_EN after 5 CALC edges → abort to IDLE; MUL_R never rises; Product stays 0x0010.
- Change A/B every cycle during CALC of 2*3 → Product=0x0006 (operands latched at the start edge only).

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Datapath package for the MUL extension: state encoding, width and
// magnitude/negate helpers shared with the ALU.
package seq_multiplier_pkg;

  localparam int unsigned MUL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Unsigned magnitude of a two's-complement value; the most negative value maps onto itself.
  function automatic logic [MUL_WIDTH-1:0] abs_val(input logic [MUL_WIDTH-1:0] x);
    return x[MUL_WIDTH-1] ? (~x + MUL_WIDTH'(1)) : x;
  endfunction

  function automatic logic [2*MUL_WIDTH-1:0] neg_val(input logic [2*MUL_WIDTH-1:0] x);
    return ~x + (2*MUL_WIDTH)'(1);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Multi-cycle signed multiplier for the MUL instruction: sign-magnitude
// shift-add over WIDTH cycles, handshaked with the ISDU via MUL_EN/MUL_R.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             MUL_EN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Product,
  output logic             Overflow,
  output logic             MUL_R
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned AW = 2 * WIDTH;

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic             sign_q, sign_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [AW-1:0]    acc_add;
  logic [AW-1:0]    signed_full;
  logic             last_iter;
  logic             full_ovf;

  // Magnitudes of the raw operands; the most negative value stays as its own magnitude.
  assign a_mag = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
  assign b_mag = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;

  assign acc_add     = mplier_q[0] ? (acc_q + ({{WIDTH{1'b0}}, mcand_q} << count_q)) : acc_q;
  assign signed_full = sign_q ? (~acc_add + AW'(1)) : acc_add;
  assign last_iter   = (count_q == CW'(WIDTH - 1));

  // Result fits iff the upper half plus the result sign bit are all equal.
  assign full_ovf = !((&signed_full[AW-1:WIDTH-1]) || (~|signed_full[AW-1:WIDTH-1]));

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    sign_d     = sign_q;
    count_d    = count_q;
    product_d  = product_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (MUL_EN) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          sign_d   = A[WIDTH-1] ^ B[WIDTH-1];
          acc_d    = '0;
          count_d  = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (!MUL_EN) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_add;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CW'(1);
          if (last_iter) begin
            state_d    = DONE;
            product_d  = signed_full[WIDTH-1:0];
            overflow_d = full_ovf;
          end
        end
      end
      DONE: begin
        if (!MUL_EN) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      sign_q     <= 1'b0;
      count_q    <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      sign_q     <= sign_d;
      count_q    <= count_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign Product  = product_q;
  assign Overflow = overflow_q;
  assign MUL_R    = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: expected results queued at each start edge and
// compared when MUL_R rises, plus reset, abort and operand-latching scenarios.
module tb_seq_multiplier;

  localparam int unsigned W = 16;
  localparam int MaxWait = 40;

  typedef struct {
    logic [W-1:0] p;
    logic         o;
  } exp_t;

  logic         Clk;
  logic         Reset;
  logic         MUL_EN;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Product;
  logic         Overflow;
  logic         MUL_R;

  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  seq_multiplier #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .MUL_EN   (MUL_EN),
    .A        (A),
    .B        (B),
    .Product  (Product),
    .Overflow (Overflow),
    .MUL_R    (MUL_R)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [2*W-1:0] full;
    full = $signed(a) * $signed(b);
    e.p  = full[W-1:0];
    e.o  = !((full[2*W-1:W-1] == '0) || (full[2*W-1:W-1] == '1));
    return e;
  endfunction

  // Start a multiply with MUL_EN held, check latency and result, then release.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        input string name);
    exp_t e;
    int   lat;
    logic [W-1:0] held_p;
    @(negedge Clk);
    A = a;
    B = b;
    MUL_EN = 1'b1;
    sb.push_back(model(a, b));
    @(posedge Clk);
    lat = 0;
    do begin
      @(posedge Clk);
      #1;
      lat++;
    end while (!MUL_R && lat < MaxWait);
    n_checks++;
    if (lat != W) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, required %0d", name, lat, W);
    end
    e = sb.pop_front();
    n_checks++;
    if (Product !== e.p || Overflow !== e.o) begin
      n_fail++;
      $display("FAIL %s result: got P=%h O=%b, required P=%h O=%b", name, Product, Overflow,
               e.p, e.o);
    end
    held_p = Product;
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk);
      #1;
      n_checks++;
      if (MUL_R !== 1'b1 || Product !== held_p) begin
        n_fail++;
        $display("FAIL %s hold: got R=%b P=%h, required R=1 P=%h", name, MUL_R, Product, held_p);
      end
    end
    @(negedge Clk);
    MUL_EN = 1'b0;
    @(posedge Clk);
    #1;
    n_checks++;
    if (MUL_R !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: got MUL_R=%b, required 0", name, MUL_R);
    end
  endtask

  task automatic test_reset();
    Reset  = 1'b0;
    MUL_EN = 1'b0;
    A      = '0;
    B      = '0;
    #12;
    n_checks++;
    if (Product !== '0 || Overflow !== 1'b0 || MUL_R !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got P=%h O=%b R=%b, required P=0000 O=0 R=0", Product,
               Overflow, MUL_R);
    end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_basic();
    do_mul(16'd3, 16'd5, 4, "mul_3x5");
  endtask

  task automatic test_signs();
    do_mul(16'hFFF9, 16'd6, 0, "mul_m7x6");
    do_mul(16'h0000, 16'h8000, 0, "mul_0xmin");
    do_mul(16'h7FFF, 16'd2, 0, "mul_max_x2");
    do_mul(16'h8000, 16'hFFFF, 0, "mul_min_xm1");
    do_mul(16'hFFFF, 16'hFFFF, 0, "mul_m1xm1");
    do_mul(16'h00FF, 16'hFF00, 0, "mul_mixed");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_mul(16'($urandom()), 16'($urandom_range(0, 255)), 0, "mul_rand");
    end
  endtask

  task automatic test_reset_mid_calc();
    do_mul(16'd7, 16'd9, 0, "pre_reset");
    @(negedge Clk);
    A = 16'd3;
    B = 16'd5;
    MUL_EN = 1'b1;
    repeat (5) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    n_checks++;
    if (Product !== '0 || Overflow !== 1'b0 || MUL_R !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_calc: got P=%h O=%b R=%b, required P=0000 O=0 R=0", Product,
               Overflow, MUL_R);
    end
    @(negedge Clk);
    MUL_EN = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    do_mul(16'd3, 16'd5, 0, "restart_3x5");
  endtask

  task automatic test_abort();
    logic seen_r;
    do_mul(16'd4, 16'd4, 0, "pre_abort_4x4");
    @(negedge Clk);
    A = 16'd9;
    B = 16'd9;
    MUL_EN = 1'b1;
    seen_r = 1'b0;
    @(posedge Clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1;
      seen_r |= MUL_R;
    end
    @(negedge Clk);
    MUL_EN = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge Clk);
      #1;
      seen_r |= MUL_R;
    end
    n_checks++;
    if (seen_r !== 1'b0 || Product !== 16'h0010) begin
      n_fail++;
      $display("FAIL abort: got seen_R=%b P=%h, required seen_R=0 P=0010", seen_r, Product);
    end
  endtask

  task automatic test_operand_latch();
    exp_t e;
    int   lat;
    @(negedge Clk);
    A = 16'd2;
    B = 16'd3;
    MUL_EN = 1'b1;
    sb.push_back(model(16'd2, 16'd3));
    @(posedge Clk);
    lat = 0;
    do begin
      @(negedge Clk);
      A = 16'($urandom());
      B = 16'($urandom());
      @(posedge Clk);
      #1;
      lat++;
    end while (!MUL_R && lat < MaxWait);
    e = sb.pop_front();
    n_checks++;
    if (lat != W || Product !== e.p || Overflow !== e.o) begin
      n_fail++;
      $display("FAIL operand_latch: got lat=%0d P=%h O=%b, required lat=%0d P=%h O=%b", lat,
               Product, Overflow, W, e.p, e.o);
    end
    @(negedge Clk);
    MUL_EN = 1'b0;
    @(posedge Clk);
  endtask

  task automatic test_back_to_back();
    do_mul(16'd100, 16'hFFFE, 0, "b2b_0");
    do_mul(16'h1234, 16'd16, 0, "b2b_1");
    do_mul(16'h4000, 16'd2, 0, "b2b_2");
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_signs();
    test_random();
    test_reset_mid_calc();
    test_abort();
    test_operand_latch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
